// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the native memory bus: one owner per transaction, a forced idle
// cycle between transactions, and a watchdog that aborts transactions the slave never acks.
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          FIXED_PRIO     = 1'b0
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,

    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,

    output logic [1:0]  grant,
    output logic        timeout_err
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [0:0]  r_state;
    logic [1:0]  r_grant;
    logic        r_last_m1;
    logic [15:0] r_cnt;
    logic        r_timeout_err;

    logic w_busy;
    logic w_own0;
    logic w_own1;
    logic w_owner_valid;
    logic w_expire;
    logic w_done;
    logic w_pick_m1;

    // Gating with resetn keeps a reset cycle from forwarding anything to either side.
    assign w_busy        = resetn && (r_state == ST_BUSY);
    assign w_own0        = w_busy && r_grant[0];
    assign w_own1        = w_busy && r_grant[1];
    assign w_owner_valid = (w_own0 && m0_valid) || (w_own1 && m1_valid);
    assign w_expire      = TO_EN && (r_cnt == TO_LAST) && !s_ready;
    assign w_done        = w_owner_valid && (s_ready || w_expire);

    // M1 wins alone, or on a tie when round-robin says M0 went last.
    assign w_pick_m1 = m1_valid && (!m0_valid || (!FIXED_PRIO && !r_last_m1));

    assign s_valid = w_owner_valid;
    assign s_instr = (w_own0 && m0_instr) || (w_own1 && m1_instr);
    assign s_addr  = ({32{w_own0}} & m0_addr)  | ({32{w_own1}} & m1_addr);
    assign s_wdata = ({32{w_own0}} & m0_wdata) | ({32{w_own1}} & m1_wdata);
    assign s_wstrb = ({4{w_own0}} & m0_wstrb)  | ({4{w_own1}} & m1_wstrb);

    assign m0_ready = w_own0 && w_done;
    assign m1_ready = w_own1 && w_done;
    // Read data only passes on a real slave ack, so an abort returns zero.
    assign m0_rdata = (w_own0 && s_ready) ? s_rdata : 32'h0000_0000;
    assign m1_rdata = (w_own1 && s_ready) ? s_rdata : 32'h0000_0000;

    assign grant       = r_grant;
    assign timeout_err = r_timeout_err;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state       <= ST_IDLE;
            r_grant       <= 2'b00;
            r_last_m1     <= 1'b1;
            r_cnt         <= 16'd0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (m0_valid || m1_valid) begin
                        r_state   <= ST_BUSY;
                        r_grant   <= w_pick_m1 ? 2'b10 : 2'b01;
                        r_last_m1 <= w_pick_m1;
                        r_cnt     <= 16'd0;
                    end
                end
                ST_BUSY: begin
                    if (!w_owner_valid || s_ready) begin
                        r_state <= ST_IDLE;
                        r_grant <= 2'b00;
                    end else if (w_expire) begin
                        r_state       <= ST_IDLE;
                        r_grant       <= 2'b00;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a round-robin instance with a 4-cycle watchdog and a fixed-priority
// instance with no watchdog share one stimulus; directed scenarios plus a randomized model run.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        m0_valid, m0_instr, m1_valid, m1_instr, s_ready;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, s_rdata;
    logic [3:0]  m0_wstrb, m1_wstrb;

    logic        m0_ready [2];
    logic        m1_ready [2];
    logic [31:0] m0_rdata [2];
    logic [31:0] m1_rdata [2];
    logic        s_valid [2];
    logic        s_instr [2];
    logic [31:0] s_addr [2];
    logic [31:0] s_wdata [2];
    logic [3:0]  s_wstrb [2];
    logic [1:0]  grant [2];
    logic        timeout_err [2];

    int checks = 0;
    int errors = 0;

    // Reference model state per instance: owner 0 = none, 1 = M0, 2 = M1.
    int md_own [2];
    int md_cnt [2];
    int md_last [2];
    bit md_terr [2];

    always #5 clk = ~clk;

    mem_bus_arbiter #(.TIMEOUT_CYCLES(4), .FIXED_PRIO(1'b0)) u_rr (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_ready(m0_ready[0]), .m0_rdata(m0_rdata[0]),
        .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_ready(m1_ready[0]), .m1_rdata(m1_rdata[0]),
        .s_valid(s_valid[0]), .s_instr(s_instr[0]), .s_addr(s_addr[0]), .s_wdata(s_wdata[0]),
        .s_wstrb(s_wstrb[0]), .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(grant[0]), .timeout_err(timeout_err[0])
    );

    mem_bus_arbiter #(.TIMEOUT_CYCLES(0), .FIXED_PRIO(1'b1)) u_fp (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_ready(m0_ready[1]), .m0_rdata(m0_rdata[1]),
        .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_ready(m1_ready[1]), .m1_rdata(m1_rdata[1]),
        .s_valid(s_valid[1]), .s_instr(s_instr[1]), .s_addr(s_addr[1]), .s_wdata(s_wdata[1]),
        .s_wstrb(s_wstrb[1]), .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(grant[1]), .timeout_err(timeout_err[1])
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        m0_valid = 0; m0_instr = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
        m1_valid = 0; m1_instr = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
        s_ready = 0; s_rdata = 0;
    endtask

    task automatic do_reset;
        idle_inputs();
        resetn = 0;
        step();
        step();
        resetn = 1;
    endtask

    task automatic test_reset;
        idle_inputs();
        resetn = 0;
        m0_valid = 1;
        s_ready = 1;
        s_rdata = 32'hFFFF_FFFF;
        step();
        step();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({grant[d], s_valid[d], timeout_err[d], m0_ready[d], m1_ready[d], s_instr[d],
                 s_addr[d], s_wdata[d], s_wstrb[d], m0_rdata[d], m1_rdata[d]} !== '0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: grant=%b s_valid=%b terr=%b rdy=%b%b got nonzero, required all zero",
                         d, grant[d], s_valid[d], timeout_err[d], m0_ready[d], m1_ready[d]);
            end
        end
        idle_inputs();
        resetn = 1;
        step();
    endtask

    task automatic test_single_read;
        m0_valid = 1; m0_addr = 32'h0000_0010; m0_wstrb = 4'b0000;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (s_valid[d] !== 1'b0) begin
                errors++; $display("FAIL rd_c0_svalid dut%0d: got %b required 0", d, s_valid[d]);
            end
        end
        step();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({grant[d], s_valid[d], s_addr[d]} !== {2'b01, 1'b1, 32'h0000_0010}) begin
                errors++;
                $display("FAIL rd_c1_grant dut%0d: got grant=%b s_valid=%b s_addr=%h required 01 1 00000010",
                         d, grant[d], s_valid[d], s_addr[d]);
            end
        end
        step();
        s_ready = 1; s_rdata = 32'h1234_5678;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({m0_ready[d], m0_rdata[d], m1_ready[d]} !== {1'b1, 32'h1234_5678, 1'b0}) begin
                errors++;
                $display("FAIL rd_c2_ready dut%0d: got m0_ready=%b m0_rdata=%h m1_ready=%b required 1 12345678 0",
                         d, m0_ready[d], m0_rdata[d], m1_ready[d]);
            end
        end
        step();
        m0_valid = 0; s_ready = 0;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({grant[d], s_valid[d]} !== 3'b000) begin
                errors++;
                $display("FAIL rd_c3_idle dut%0d: got grant=%b s_valid=%b required 00 0",
                         d, grant[d], s_valid[d]);
            end
        end
    endtask

    // Both masters request continuously; the slave acks one cycle after s_valid.
    task automatic test_alternation;
        logic [1:0] gprev [2];
        logic [1:0] gexp;
        int         n [2];
        logic       prev_sv;
        do_reset();
        m0_valid = 1; m1_valid = 1; m0_addr = 32'h100; m1_addr = 32'h200;
        prev_sv = 0;
        gprev = '{2'b00, 2'b00};
        n = '{0, 0};
        for (int c = 0; c < 12; c++) begin
            s_ready = prev_sv;
            s_rdata = $urandom;
            #1;
            for (int d = 0; d < 2; d++) begin
                if (grant[d] != 2'b00 && gprev[d] == 2'b00) begin
                    gexp = (d == 1 || n[d] % 2 == 0) ? 2'b01 : 2'b10;
                    checks++;
                    if (grant[d] !== gexp) begin
                        errors++;
                        $display("FAIL alt_grant dut%0d #%0d: got %b required %b", d, n[d], grant[d], gexp);
                    end
                    n[d]++;
                end
                checks++;
                if (gprev[d] != 2'b00 && grant[d] != 2'b00 && grant[d] !== gprev[d]) begin
                    errors++;
                    $display("FAIL alt_gap dut%0d: grant went %b -> %b with no idle cycle", d, gprev[d], grant[d]);
                end
                checks++;
                if (grant[d] == 2'b01 && m1_ready[d] !== 1'b0) begin
                    errors++; $display("FAIL alt_m1_ready dut%0d: got 1 required 0 while grant=01", d);
                end
                gprev[d] = grant[d];
            end
            prev_sv = s_valid[0];
            step();
        end
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (n[d] != 4) begin
                errors++; $display("FAIL alt_count dut%0d: got %0d grants required 4", d, n[d]);
            end
        end
        // With M0 quiet during IDLE, M1 is finally served by the fixed-priority instance too.
        m0_valid = 0; s_ready = 0;
        step();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (grant[d] !== 2'b10) begin
                errors++; $display("FAIL fp_m1_grant dut%0d: got %b required 10", d, grant[d]);
            end
        end
        s_ready = 1;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({m1_ready[d], m0_ready[d]} !== 2'b10) begin
                errors++;
                $display("FAIL fp_m1_ready dut%0d: got m1=%b m0=%b required 1 0", d, m1_ready[d], m0_ready[d]);
            end
        end
        step();
        idle_inputs();
    endtask

    task automatic test_m1_write;
        do_reset();
        m1_valid = 1; m1_addr = 32'h0300_0000; m1_wstrb = 4'b0011; m1_wdata = 32'hA5A5_5A5A;
        m0_addr = 32'h0000_0044; m0_wdata = 32'h1111_2222; m0_wstrb = 4'b1111;
        step();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({grant[d], s_valid[d], s_addr[d], s_wstrb[d], s_wdata[d], m0_ready[d]} !==
                {2'b10, 1'b1, 32'h0300_0000, 4'b0011, 32'hA5A5_5A5A, 1'b0}) begin
                errors++;
                $display("FAIL wr_fwd dut%0d: got grant=%b s_valid=%b addr=%h wstrb=%b wdata=%h m0_ready=%b required 10 1 03000000 0011 a5a55a5a 0",
                         d, grant[d], s_valid[d], s_addr[d], s_wstrb[d], s_wdata[d], m0_ready[d]);
            end
        end
        s_ready = 1;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({m1_ready[d], m0_ready[d]} !== 2'b10) begin
                errors++;
                $display("FAIL wr_ready dut%0d: got m1=%b m0=%b required 1 0", d, m1_ready[d], m0_ready[d]);
            end
        end
        step();
        idle_inputs();
    endtask

    task automatic test_timeout;
        do_reset();
        m0_valid = 1; s_rdata = 32'hDEAD_BEEF;
        step();
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if (m0_ready[0] !== (c == 4)) begin
                errors++; $display("FAIL to_ready cycle%0d: got %b required %b", c, m0_ready[0], c == 4);
            end
            checks++;
            if (m0_ready[1] !== 1'b0) begin
                errors++; $display("FAIL to_nowd_ready cycle%0d: got %b required 0", c, m0_ready[1]);
            end
            if (c == 4) begin
                checks++;
                if ({m0_rdata[0], timeout_err[0]} !== 33'd0) begin
                    errors++;
                    $display("FAIL to_rdata: got rdata=%h terr=%b required 00000000 0", m0_rdata[0], timeout_err[0]);
                end
            end
            step();
        end
        // Late slave response in IDLE; the watchdog-less instance sees M0 drop valid instead.
        m0_valid = 0; s_ready = 1;
        #1;
        checks++;
        if ({timeout_err[0], grant[0], m0_ready[0], m1_ready[0]} !== 5'b1_00_0_0) begin
            errors++;
            $display("FAIL to_pulse: got terr=%b grant=%b rdy=%b%b required 1 00 00",
                     timeout_err[0], grant[0], m0_ready[0], m1_ready[0]);
        end
        checks++;
        if ({m0_ready[1], s_valid[1]} !== 2'b00) begin
            errors++; $display("FAIL drop_valid: got ready=%b s_valid=%b required 0 0", m0_ready[1], s_valid[1]);
        end
        step();
        s_ready = 0;
        checks++;
        if ({timeout_err[0], grant[1]} !== 3'b000) begin
            errors++;
            $display("FAIL to_after: got terr=%b fp_grant=%b required 0 00", timeout_err[0], grant[1]);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid;
        do_reset();
        m0_valid = 1;
        step();
        resetn = 0; s_ready = 1; s_rdata = 32'h0BAD_F00D;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({m0_ready[d], m1_ready[d]} !== 2'b00) begin
                errors++; $display("FAIL rst_mid_ready dut%0d: got %b%b required 00", d, m0_ready[d], m1_ready[d]);
            end
        end
        step();
        resetn = 1; m1_valid = 1; s_ready = 0;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({grant[d], s_valid[d], m0_ready[d]} !== 4'b0000) begin
                errors++;
                $display("FAIL rst_mid_idle dut%0d: got grant=%b s_valid=%b ready=%b required 00 0 0",
                         d, grant[d], s_valid[d], m0_ready[d]);
            end
        end
        step();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (grant[d] !== 2'b01) begin
                errors++; $display("FAIL rst_first_tie dut%0d: got %b required 01", d, grant[d]);
            end
        end
        s_ready = 1;
        step();
        idle_inputs();
    endtask

    task automatic test_random;
        bit          busy, ov, tmo, done, fp;
        int          to, w;
        logic [1:0]  e_grant;
        logic [68:0] e_pay, a_pay;
        do_reset();
        for (int d = 0; d < 2; d++) begin
            md_own[d] = 0; md_cnt[d] = 0; md_last[d] = 2; md_terr[d] = 0;
        end
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(5) == 0) m0_valid = ~m0_valid;
            if ($urandom_range(5) == 0) m1_valid = ~m1_valid;
            m0_instr = 1'($urandom); m0_addr = $urandom; m0_wdata = $urandom; m0_wstrb = 4'($urandom);
            m1_instr = 1'($urandom); m1_addr = $urandom; m1_wdata = $urandom; m1_wstrb = 4'($urandom);
            s_ready = ($urandom_range(2) == 0);
            s_rdata = $urandom;
            resetn = ($urandom_range(199) != 0);
            #1;
            for (int d = 0; d < 2; d++) begin
                fp = (d == 1);
                to = (d == 0) ? 4 : 0;
                busy = resetn && md_own[d] != 0;
                ov = busy && ((md_own[d] == 1) ? m0_valid : m1_valid);
                tmo = (to != 0) && (md_cnt[d] == to - 1) && !s_ready;
                done = ov && (s_ready || tmo);
                e_grant = (md_own[d] == 1) ? 2'b01 : (md_own[d] == 2) ? 2'b10 : 2'b00;
                e_pay = !busy ? '0 : (md_own[d] == 1) ? {m0_instr, m0_addr, m0_wdata, m0_wstrb}
                                                      : {m1_instr, m1_addr, m1_wdata, m1_wstrb};
                a_pay = {s_instr[d], s_addr[d], s_wdata[d], s_wstrb[d]};
                checks++;
                if ({grant[d], timeout_err[d], s_valid[d]} !== {e_grant, md_terr[d], ov}) begin
                    errors++;
                    $display("FAIL rnd_ctrl dut%0d cyc%0d: got grant=%b terr=%b s_valid=%b required %b %b %b",
                             d, c, grant[d], timeout_err[d], s_valid[d], e_grant, md_terr[d], ov);
                end
                checks++;
                if (a_pay !== e_pay) begin
                    errors++; $display("FAIL rnd_payload dut%0d cyc%0d: got %h required %h", d, c, a_pay, e_pay);
                end
                checks++;
                if ({m0_ready[d], m1_ready[d]} !== {done && md_own[d] == 1, done && md_own[d] == 2}) begin
                    errors++;
                    $display("FAIL rnd_ready dut%0d cyc%0d: got %b%b required %b%b", d, c, m0_ready[d],
                             m1_ready[d], done && md_own[d] == 1, done && md_own[d] == 2);
                end
                checks++;
                if (done && ((md_own[d] == 1) ? m0_rdata[d] : m1_rdata[d]) !== (s_ready ? s_rdata : 32'd0)) begin
                    errors++;
                    $display("FAIL rnd_rdata dut%0d cyc%0d: got %h/%h required %h", d, c, m0_rdata[d],
                             m1_rdata[d], s_ready ? s_rdata : 32'd0);
                end
                checks++;
                if ((md_own[d] != 1 && m0_rdata[d] !== 32'd0) || (md_own[d] != 2 && m1_rdata[d] !== 32'd0)) begin
                    errors++;
                    $display("FAIL rnd_nonowner_rdata dut%0d cyc%0d: got %h/%h required zero for non-owner",
                             d, c, m0_rdata[d], m1_rdata[d]);
                end
                // Advance the model to what the next edge should produce.
                if (!resetn) begin
                    md_own[d] = 0; md_cnt[d] = 0; md_last[d] = 2; md_terr[d] = 0;
                end else begin
                    md_terr[d] = 0;
                    if (md_own[d] == 0) begin
                        if (m0_valid || m1_valid) begin
                            if (m0_valid && m1_valid) w = fp ? 1 : (md_last[d] == 1 ? 2 : 1);
                            else w = m0_valid ? 1 : 2;
                            md_own[d] = w; md_last[d] = w; md_cnt[d] = 0;
                        end
                    end else if (!ov || s_ready) begin
                        md_own[d] = 0;
                    end else if (tmo) begin
                        md_own[d] = 0; md_terr[d] = 1;
                    end else begin
                        md_cnt[d]++;
                    end
                end
            end
            step();
        end
        resetn = 1;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        resetn = 0;
        test_reset();
        test_single_read();
        test_alternation();
        test_m1_write();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
